// File: rtl/pdw_cic_receiver.sv
// PDM microphone front end: generates pdwClk, captures one or two interleaved channels, CIC-decimates to PCM.
// Latency: sampleValid fires CIC_ORDER+2 clk48 cycles after the L strobe that closes a decimation window.
// Backpressure: none; output is a one-cycle strobe, enable low flushes the datapath but holds the last samples.
module pdw_cic_receiver #(
  parameter int CLK_DIV   = 16,  // clk48 cycles per pdwClk period, even, >= 2*(CIC_ORDER+3)
  parameter int CHANNELS  = 2,   // 1 = left only, 2 = left and right
  parameter int CIC_ORDER = 3,   // integrator/comb stages, 1..5
  parameter int DECIM     = 64,  // pdwClk periods per output sample, power of two, >= 4
  parameter int OUT_WIDTH = 16
) (
  input  logic                        clk48,
  input  logic                        nReset,
  input  logic                        enable,
  output logic                        pdwClk,
  input  logic                        pdwData,
  output logic signed [OUT_WIDTH-1:0] sampleL,
  output logic signed [OUT_WIDTH-1:0] sampleR,
  output logic                        sampleValid
);

  localparam int LOG_DECIM = $clog2(DECIM);
  // Register growth of an N-stage CIC is N*log2(R) bits; +2 covers the +/-1 input and its sign.
  localparam int W         = CIC_ORDER * LOG_DECIM + 2;
  localparam int DIV_W     = $clog2(CLK_DIV);
  localparam int EXT_W     = (W > OUT_WIDTH) ? W : OUT_WIDTH;

  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]     DIV_MID  = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [LOG_DECIM-1:0] DEC_LAST = LOG_DECIM'(DECIM - 1);

  // Top OUT_WIDTH bits of a W-bit value; a narrower W is left-justified with zero LSBs.
  function automatic logic [OUT_WIDTH-1:0] top_bits(input logic [W-1:0] v);
    logic [EXT_W-1:0] ext;
    ext = EXT_W'(v) << (EXT_W - W);
    return OUT_WIDTH'(ext >> (EXT_W - OUT_WIDTH));
  endfunction

  // Divider and clock
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pdw_clk_q, pdw_clk_d;

  // Input synchronizer; sync_q[1] is the usable data bit
  logic [1:0] sync_q, sync_d;

  // Capture strobes: bit 0 = L (pdwClk driven 1->0), bit 1 = R (pdwClk driven 0->1)
  logic [CHANNELS-1:0] stb;

  // Integrator chains, wrap-around arithmetic
  logic [W-1:0] integ_q [CHANNELS][CIC_ORDER];
  logic [W-1:0] integ_d [CHANNELS][CIC_ORDER];

  // Decimation
  logic [LOG_DECIM-1:0] decim_cnt_q, decim_cnt_d;
  logic                 latch_q, latch_d;

  // Comb pipeline: comb_q[c][k] is the input to comb stage k, dly_q[c][k] its delayed sample
  logic [CIC_ORDER-1:0] vld_q, vld_d;
  logic [W-1:0]         comb_q [CHANNELS][CIC_ORDER];
  logic [W-1:0]         comb_d [CHANNELS][CIC_ORDER];
  logic [W-1:0]         dly_q  [CHANNELS][CIC_ORDER];
  logic [W-1:0]         dly_d  [CHANNELS][CIC_ORDER];

  // Output registers
  logic [OUT_WIDTH-1:0] samp_q [CHANNELS];
  logic [OUT_WIDTH-1:0] samp_d [CHANNELS];
  logic                 valid_q, valid_d;

  // Divider next state: pdwClk rises after the mid count and falls after the last count.
  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
    pdw_clk_d = pdw_clk_q;
    if (div_cnt_q == DIV_MID) begin
      pdw_clk_d = 1'b1;
    end else if (div_cnt_q == DIV_LAST) begin
      pdw_clk_d = 1'b0;
    end
    sync_d = {sync_q[0], pdwData};
  end

  // Capture strobes are decoded from the divider, so they coincide with the registered pdwClk edges.
  always_comb begin
    stb    = '0;
    stb[0] = (div_cnt_q == DIV_LAST);
    if (CHANNELS == 2) begin
      stb[CHANNELS-1] = (div_cnt_q == DIV_MID);
    end
  end

  // Integrators: every stage advances on its channel strobe using the previous values (pipelined chain).
  always_comb begin
    integ_d = integ_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (stb[c]) begin
        integ_d[c][0] = integ_q[c][0] + (sync_q[1] ? W'(1) : {W{1'b1}});
        for (int k = 1; k < CIC_ORDER; k++) begin
          integ_d[c][k] = integ_q[c][k] + integ_q[c][k-1];
        end
      end
    end
  end

  // Decimation counter runs on L strobes; the window-closing strobe arms a latch for the next cycle.
  always_comb begin
    decim_cnt_d = decim_cnt_q;
    latch_d     = 1'b0;
    if (stb[0]) begin
      decim_cnt_d = decim_cnt_q + LOG_DECIM'(1);
      latch_d     = (decim_cnt_q == DEC_LAST);
    end
  end

  // Comb pipeline: one stage per cycle, each delay register moves only when its stage holds a sample.
  always_comb begin
    comb_d   = comb_q;
    dly_d    = dly_q;
    samp_d   = samp_q;
    vld_d    = '0;
    vld_d[0] = latch_q;
    for (int k = 1; k < CIC_ORDER; k++) begin
      vld_d[k] = vld_q[k-1];
    end
    valid_d = vld_q[CIC_ORDER-1];
    for (int c = 0; c < CHANNELS; c++) begin
      if (latch_q) begin
        comb_d[c][0] = integ_q[c][CIC_ORDER-1];
      end
      for (int k = 1; k < CIC_ORDER; k++) begin
        if (vld_q[k-1]) begin
          comb_d[c][k]  = comb_q[c][k-1] - dly_q[c][k-1];
          dly_d[c][k-1] = comb_q[c][k-1];
        end
      end
      if (vld_q[CIC_ORDER-1]) begin
        dly_d[c][CIC_ORDER-1] = comb_q[c][CIC_ORDER-1];
        samp_d[c]             = top_bits(comb_q[c][CIC_ORDER-1] - dly_q[c][CIC_ORDER-1]);
      end
    end
  end

  // Divider, clock and synchronizer state; disabled behaves as reset.
  always_ff @(posedge clk48) begin
    if (!nReset || !enable) begin
      div_cnt_q <= '0;
      pdw_clk_q <= 1'b0;
      sync_q    <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pdw_clk_q <= pdw_clk_d;
      sync_q    <= sync_d;
    end
  end

  // Integrator and decimation state; disabled behaves as reset.
  always_ff @(posedge clk48) begin
    if (!nReset || !enable) begin
      decim_cnt_q <= '0;
      latch_q     <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < CIC_ORDER; k++) begin
          integ_q[c][k] <= '0;
        end
      end
    end else begin
      decim_cnt_q <= decim_cnt_d;
      latch_q     <= latch_d;
      integ_q     <= integ_d;
    end
  end

  // Comb state; disabling drops any sample still in flight so no strobe escapes.
  always_ff @(posedge clk48) begin
    if (!nReset || !enable) begin
      vld_q   <= '0;
      valid_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < CIC_ORDER; k++) begin
          comb_q[c][k] <= '0;
          dly_q[c][k]  <= '0;
        end
      end
    end else begin
      vld_q   <= vld_d;
      valid_q <= valid_d;
      comb_q  <= comb_d;
      dly_q   <= dly_d;
    end
  end

  // PCM sample registers: cleared only by reset, held while disabled.
  always_ff @(posedge clk48) begin
    if (!nReset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        samp_q[c] <= '0;
      end
    end else if (enable) begin
      samp_q <= samp_d;
    end
  end

  assign pdwClk      = pdw_clk_q;
  assign sampleL     = samp_q[0];
  assign sampleValid = valid_q;

  if (CHANNELS == 2) begin : g_right
    assign sampleR = samp_q[CHANNELS-1];
  end else begin : g_mono
    assign sampleR = '0;
  end

endmodule

// File: doc/pdw_cic_receiver.md
Name: pdw_cic_receiver

Overview:
- Parametrised successor to the single-channel PDW (PDM) microphone front end.
- Generates pdwClk from clk48 and captures one or two interleaved channels from pdwData, sampling on both pdwClk edges.
- Each channel is decimated through a CIC_ORDER-stage CIC filter into signed OUT_WIDTH-bit PCM.
- Output feeds the sonar correlator and the PWM/speaker path.

Parameters:
- CLK_DIV, 16: clk48 cycles per pdwClk period. Must be even and >= 2*(CIC_ORDER+3). Default gives 3 MHz.
- CHANNELS, 2: 1 = left only; 2 = left and right.
- CIC_ORDER, 3: number of integrator/comb stages, 1..5.
- DECIM, 64: pdwClk periods per output sample. Power of two, >= 4.
- OUT_WIDTH, 16: output sample width.

Ports:
- clk48  in  1  system clock, 48 MHz.
- nReset  in  1  synchronous, active-low reset.
- enable  in  1  run/stop. Low flushes the datapath.
- pdwClk  out  1  microphone clock.
- pdwData  in  1  microphone data, asynchronous to clk48.
- sampleL  out  OUT_WIDTH  left PCM sample, signed.
- sampleR  out  OUT_WIDTH  right PCM sample, signed. Held 0 when CHANNELS=1.
- sampleValid  out  1  one-cycle strobe: new sampleL/sampleR.

Behaviour:
- Clock and reset: one clock, clk48. Reset nReset is synchronous and active-low, sampled on the clk48 rising edge.
- Reset values: pdwClk=0, sampleL=0, sampleR=0, sampleValid=0. All counters, integrators, comb delays and synchronizer flops are 0.
- enable low: same clearing as reset, except sampleL/sampleR hold their last values. Any pending output is discarded, with no sampleValid.
- Divider:
  - divCnt counts 0..CLK_DIV-1 while enable=1, starting at 0 on the first enabled cycle.
  - pdwClk is registered: it goes 1 on the edge where divCnt==CLK_DIV/2-1 and 0 on the edge where divCnt==CLK_DIV-1.
- Input sync: pdwData passes through a 2-flop synchronizer (pdwSync).
- Capture:
  - L strobe: the cycle pdwClk is driven 1→0, i.e. the end of the high phase. Captures pdwSync.
  - R strobe: the cycle pdwClk is driven 0→1. Captures pdwSync. Only active when CHANNELS=2.
- Input mapping: bit 1 → +1, bit 0 → −1.
- Integrators:
  - Width W = CIC_ORDER*log2(DECIM)+2 bits, two's complement.
  - Arithmetic wraps modulo 2^W. Overflow is required and intentional, never saturated.
  - Each channel's integrator chain advances one step on its own capture strobe, all stages in the same cycle.
- Decimation:
  - decimCnt counts L strobes 0..DECIM-1 and wraps.
  - The cycle after the L strobe on which decimCnt wraps DECIM-1→0, the current last-integrator value of each channel is latched into the comb pipeline.
- Comb:
  - One stage per clk48 cycle, CIC_ORDER cycles, W-bit wrap arithmetic.
  - Each stage's delay register updates only on its decimated sample.
- Output:
  - Top OUT_WIDTH bits of the W-bit comb result. If W < OUT_WIDTH, left-justify with zero LSBs.
  - sampleL/sampleR update and sampleValid=1 for exactly one cycle, CIC_ORDER+2 cycles after the wrapping L strobe.
  - Thereafter sampleValid recurs every DECIM*CLK_DIV cycles.
- Settling: the first CIC_ORDER outputs after reset or enable are transient. From output CIC_ORDER+1 onward, a constant input gives exactly ±DECIM^CIC_ORDER scaled. Defaults: +16384 (0x4000) / −16384 (0xC000).
- Simultaneous events:
  - nReset low overrides enable.
  - The L strobe and the comb pipeline may overlap; they use independent registers.
- CHANNELS=1: the R datapath is not built and sampleR is constant 0.

Test Plan:
1. nReset low 5 cycles, enable=1 → all outputs 0, pdwClk=0. After release: pdwClk rises on the cycle-8 edge and falls on the cycle-16 edge, period 16.
2. pdwData=1 constant, defaults → sampleValid every 1024 cycles. From the 4th strobe on, sampleL=sampleR=0x4000. pdwData=0 gives 0xC000.
3. Drive pdwData=pdwClk (high in high phase, low in low phase) → settled sampleL=0x4000, sampleR=0xC000.
4. pdwData toggled on each pdwClk falling edge → both channels settle to 0x0000.
5. Constant 1 for 200 outputs (last integrator wraps repeatedly) → every settled output stays 0x4000.
6. Drop enable 500 cycles after a sampleValid → no further strobe, pdwClk=0 next cycle, samples held. Re-enable → first strobe at 64*16+5 cycles. CHANNELS=1 build: sampleR stays 0.
